// File: rtl/vedic_mac_acc.sv
// vedic_mac_acc: accumulates N unsigned 8-bit Vedic multiplier products per frame and hands off the sum
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   clr        synchronous frame abort (priority over beats and handshakes)
//   in_prod    8-bit unsigned product, in_valid/in_ready input handshake
//   out_sum    completed frame sum (ACC_W bits), out_ovf sticky frame overflow
//   out_valid/out_ready result handshake
// Define VEDIC_MAC_SAT_EN to clamp the accumulator at 2^ACC_W-1 instead of wrapping.
module vedic_mac_acc #(
    parameter int N     = 8,
    parameter int ACC_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [7:0]       in_prod,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf,
    output logic             out_valid,
    input  logic             out_ready
);
    typedef enum logic {ACC, DONE} state_t;
    state_t           r_state, w_next;
    logic [ACC_W-1:0] r_acc, w_acc;
    logic [7:0]       r_cnt;
    logic             r_ovf;
    logic [ACC_W:0]   w_add;
    logic             w_accept, w_last, w_flush;

    // one extra bit exposes the carry out of the accumulator
    assign w_add    = {1'b0, r_acc} + (ACC_W+1)'(in_prod);
    assign w_accept = in_valid && in_ready;
    assign w_last   = w_accept && (r_cnt == 8'(N - 1));
    assign w_flush  = clr || (out_valid && out_ready);
`ifdef VEDIC_MAC_SAT_EN
    // once the frame has overflowed it stays pinned at full scale
    assign w_acc = (r_ovf || w_add[ACC_W]) ? '1 : w_add[ACC_W-1:0];
`else
    assign w_acc = w_add[ACC_W-1:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ACC;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = clr ? ACC : (r_state == ACC) ? (w_last ? DONE : ACC) : (out_ready ? ACC : DONE);
        in_ready  = (r_state == ACC);
        out_valid = (r_state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_flush) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_acc <= w_acc;
            r_cnt <= r_cnt + 8'd1;
            r_ovf <= r_ovf | w_add[ACC_W];
        end
    end

    assign out_sum = r_acc;
    assign out_ovf = r_ovf;
endmodule

// File: tb/tb_vedic_mac_acc.sv
// tb_vedic_mac_acc: directed checks of frame accumulation, handshakes, overflow, clr and async reset
module tb_vedic_mac_acc;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic [7:0]  in_prod = '0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready, out_ovf, out_valid;
    logic [11:0] out_sum;
    logic        in_ready10, out_ovf10, out_valid10;
    logic [9:0]  out_sum10;
    int          checks = 0;
    int          errors = 0;

`ifdef VEDIC_MAC_SAT_EN
    localparam int EXP10 = 1023;
`else
    localparam int EXP10 = 776;
`endif

    vedic_mac_acc #(.N(8), .ACC_W(12)) dut (
        .clk(clk), .rst(rst), .clr(clr), .in_prod(in_prod), .in_valid(in_valid),
        .in_ready(in_ready), .out_sum(out_sum), .out_ovf(out_ovf),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    vedic_mac_acc #(.N(8), .ACC_W(10)) dut10 (
        .clk(clk), .rst(rst), .clr(clr), .in_prod(in_prod), .in_valid(in_valid),
        .in_ready(in_ready10), .out_sum(out_sum10), .out_ovf(out_ovf10),
        .out_valid(out_valid10), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] v);
        in_valid = 1'b1;
        in_prod  = v;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({in_ready, out_valid, out_ovf} !== 3'b100 || out_sum !== 12'd0) begin
            errors++;
            $display("FAIL reset_during got rdy/vld/ovf=%b sum=%0d exp 100 sum=0", {in_ready, out_valid, out_ovf}, out_sum);
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({in_ready, out_valid, out_ovf} !== 3'b100 || out_sum !== 12'd0) begin
            errors++;
            $display("FAIL reset_after got rdy/vld/ovf=%b sum=%0d exp 100 sum=0", {in_ready, out_valid, out_ovf}, out_sum);
        end
    endtask

    task automatic test_full_frame();
        in_valid = 1'b1;
        in_prod  = 8'd225;
        for (int i = 0; i < 7; i++) tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 12'd1575) begin
            errors++;
            $display("FAIL full_7beats got vld=%b rdy=%b sum=%0d exp vld=0 rdy=1 sum=1575", out_valid, in_ready, out_sum);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 12'd1800 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL full_done got vld=%b rdy=%b sum=%0d ovf=%b exp 1 0 1800 0", out_valid, in_ready, out_sum, out_ovf);
        end
        checks++;
        if (out_valid10 !== 1'b1 || out_sum10 !== 10'(EXP10) || out_ovf10 !== 1'b1) begin
            errors++;
            $display("FAIL ovf_accw10 got vld=%b sum=%0d ovf=%b exp 1 %0d 1", out_valid10, out_sum10, out_ovf10, EXP10);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            in_prod  = 8'd9;
            tick();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 12'd1800) begin
                errors++;
                $display("FAIL backpressure_hold%0d got vld=%b rdy=%b sum=%0d exp 1 0 1800", i, out_valid, in_ready, out_sum);
            end
        end
        in_valid = 1'b1;
        in_prod  = 8'd50;
        drain();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 12'd0 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL handshake_release got rdy=%b vld=%b sum=%0d ovf=%b exp 1 0 0 0", in_ready, out_valid, out_sum, out_ovf);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_sum !== 12'd50) begin
            errors++;
            $display("FAIL next_frame_first got sum=%0d exp 50", out_sum);
        end
        for (int i = 0; i < 7; i++) beat(8'd0);
        drain();
        checks++;
        if (out_sum10 !== 10'd0 || out_ovf10 !== 1'b0) begin
            errors++;
            $display("FAIL ovf_cleared got sum10=%0d ovf10=%b exp 0 0", out_sum10, out_ovf10);
        end
    endtask

    task automatic test_gapped();
        for (int i = 1; i <= 8; i++) begin
            beat(8'(i));
            tick();
            if (i == 7) begin
                checks++;
                if (out_valid !== 1'b0 || out_sum !== 12'd28) begin
                    errors++;
                    $display("FAIL gapped_partial got vld=%b sum=%0d exp 0 28", out_valid, out_sum);
                end
            end
        end
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 12'd36 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL gapped_done got vld=%b sum=%0d ovf=%b exp 1 36 0", out_valid, out_sum, out_ovf);
        end
        drain();
    endtask

    task automatic test_clr();
        for (int i = 0; i < 3; i++) beat(8'd100);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_prod  = 8'd100;
        tick();
        clr      = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_sum !== 12'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL clr_beat_dropped got sum=%0d rdy=%b exp 0 1", out_sum, in_ready);
        end
        for (int i = 0; i < 7; i++) beat(8'd1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL clr_count_cleared got vld=%b exp 0", out_valid);
        end
        beat(8'd1);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 12'd8) begin
            errors++;
            $display("FAIL clr_next_frame got vld=%b sum=%0d exp 1 8", out_valid, out_sum);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 12'd0) begin
            errors++;
            $display("FAIL clr_in_done got vld=%b rdy=%b sum=%0d exp 0 1 0", out_valid, in_ready, out_sum);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) beat(8'd7);
        #3 rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 12'd0) begin
            errors++;
            $display("FAIL rst_mid_frame got rdy=%b vld=%b sum=%0d exp 1 0 0", in_ready, out_valid, out_sum);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) beat(8'd2);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 12'd16) begin
            errors++;
            $display("FAIL rst_no_stale got vld=%b sum=%0d exp 1 16", out_valid, out_sum);
        end
        #3 rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 12'd0 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL rst_in_done got rdy=%b vld=%b sum=%0d ovf=%b exp 1 0 0 0", in_ready, out_valid, out_sum, out_ovf);
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_sum !== 12'd0) begin
            errors++;
            $display("FAIL rst_release got vld=%b sum=%0d exp 0 0", out_valid, out_sum);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_backpressure();
        test_gapped();
        test_clr();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vedic_mac_acc.md
VEDIC_MAC_ACC -- requirements
Module: vedic_mac_acc

Interface
REQ-001 SHALL have parameter N, default 8: number of products per accumulation frame (2..255).
REQ-002 SHALL have parameter ACC_W, default 12: accumulator width (8..32).
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port clr, input, 1: synchronous frame abort.
REQ-006 SHALL have port in_prod, input, 8: unsigned product from the 4x4 Vedic multiplier (0..225).
REQ-007 SHALL have port in_valid, input, 1: in_prod valid.
REQ-008 SHALL have port in_ready, output, 1: block accepts in_prod this cycle.
REQ-009 SHALL have port out_sum, output, ACC_W: completed frame sum.
REQ-010 SHALL have port out_ovf, output, 1: frame overflowed ACC_W.
REQ-011 SHALL have port out_valid, output, 1: out_sum/out_ovf valid.
REQ-012 SHALL have port out_ready, input, 1: downstream accepts the result.

Function
REQ-013 SHALL implement FSM states ACC and DONE only.
REQ-014 In ACC, in_ready SHALL be 1 and out_valid 0; in DONE, in_ready SHALL be 0 and out_valid 1.
REQ-015 A beat SHALL be accepted when in_valid and in_ready are both 1 on a rising edge; acc <= acc + in_prod, beat count +1.
REQ-016 The accepted beat that makes count = N SHALL move ACC->DONE; out_sum SHALL show the full N-product sum in the next cycle (latency 1 cycle from last beat).
REQ-017 In DONE, out_sum and out_ovf SHALL hold stable until out_valid and out_ready are both 1.
REQ-018 The DONE handshake SHALL move DONE->ACC, clear acc, count and overflow; a new beat SHALL be accepted in the following cycle (no same-cycle bypass).
REQ-019 Addition SHALL be performed at ACC_W+1 bits; a carry out of bit ACC_W-1 SHALL set a sticky overflow flag for the frame.
REQ-020 Without saturation (see Configuration), acc SHALL wrap modulo 2^ACC_W on overflow.
REQ-021 clr=1 SHALL, in either state, force ACC and clear acc, count and overflow on the next edge; clr SHALL take priority over a same-cycle input beat or output handshake.
REQ-022 in_valid=0 cycles SHALL leave acc and count unchanged; beats need not be contiguous.
REQ-023 in_prod SHALL be zero-extended to ACC_W before addition.

Reset
REQ-024 rst=1 SHALL asynchronously force state ACC, acc=0, count=0, overflow=0.
REQ-025 During and after reset, outputs SHALL be in_ready=1, out_valid=0, out_sum=0, out_ovf=0.
REQ-026 Reset asserted mid-frame or in DONE SHALL discard the partial or pending result with no output handshake.

Configuration
REQ-027 Macro VEDIC_MAC_SAT_EN SHALL select saturating accumulation.
REQ-028 With VEDIC_MAC_SAT_EN defined, acc SHALL clamp to 2^ACC_W-1 on overflow and stay there for the rest of the frame; out_ovf SHALL still be set.
REQ-029 Without VEDIC_MAC_SAT_EN, acc SHALL wrap as in REQ-020; out_ovf behaviour SHALL be identical.

Verification
REQ-030 Default params, 8 beats of in_prod=225 with in_valid held high -> out_valid one cycle after 8th beat, out_sum=1800, out_ovf=0, in_ready=0 while in DONE.
REQ-031 Backpressure: out_ready=0 for 5 cycles in DONE -> out_sum held at 1800, in_valid pulses ignored; out_ready=1 -> in_ready=1 next cycle, next frame starts from 0.
REQ-032 ACC_W=10, 8 beats of 225: without macro -> out_sum=776 (1800 mod 1024), out_ovf=1; with VEDIC_MAC_SAT_EN -> out_sum=1023, out_ovf=1.
REQ-033 Gapped input: beats 1,2,3,4,5,6,7,8 with idle cycles between -> out_sum=36, out_ovf=0.
REQ-034 clr after 3 beats of 100 together with in_valid=1 -> beat dropped, then 8 beats of 1 -> out_sum=8.
REQ-035 rst asserted asynchronously mid-frame and in DONE -> outputs immediately in_ready=1, out_valid=0, out_sum=0; no stale result after release.
